// File: rtl/ats_eligibility_calc.sv
// Per-stream ATS token-bucket stage: stamps arrivals, computes eligibility
// time or discard, and hands the result to the eligibility queue.
module ats_eligibility_calc #(
  parameter int TIMESTAMP_WIDTH = 59,
  parameter int LEN_WIDTH       = 16,
  parameter int RATE_WIDTH      = 24,
  parameter int TAG_WIDTH       = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [TIMESTAMP_WIDTH-1:0] local_clock,
  input  logic [RATE_WIDTH-1:0]      cfg_ps_per_byte,
  input  logic [RATE_WIDTH-1:0]      cfg_cbs_bytes,
  input  logic [TIMESTAMP_WIDTH-1:0] cfg_max_residence,
  input  logic                       cfg_load,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LEN_WIDTH-1:0]       in_frame_len,
  input  logic [TAG_WIDTH-1:0]       in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TIMESTAMP_WIDTH-1:0] out_elig_time,
  output logic                       out_discard,
  output logic [TAG_WIDTH-1:0]       out_tag
);

  localparam int TW = TIMESTAMP_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_CMP,
    S_DEC,
    S_OUT
  } state_t;

  state_t state_q, state_d;

  logic [TW-1:0]         arrival_q, arrival_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [TW-1:0]         lrd_q, lrd_d;
  logic [TW-1:0]         etf_q, etf_d;
  logic [TW-1:0]         bucket_empty_q, bucket_empty_d;
  logic [TW-1:0]         group_elig_q, group_elig_d;
  logic                  init_flag_q, init_flag_d;
  logic [TW-1:0]         sched_et_q, sched_et_d;
  logic [TW-1:0]         bucket_full_q, bucket_full_d;
  logic [TW-1:0]         elig_q, elig_d;
  logic                  out_valid_q, out_valid_d;
  logic [TW-1:0]         out_elig_time_q, out_elig_time_d;
  logic                  out_discard_q, out_discard_d;
  logic [TAG_WIDTH-1:0]  out_tag_q, out_tag_d;

  logic [LEN_WIDTH+RATE_WIDTH-1:0] lrd_prod;
  logic [2*RATE_WIDTH-1:0]         etf_prod;
  logic [TW-1:0]                   residence;
  logic                            discard;

  // Wrap-aware ordering: a is earlier than b when a-b is negative.
  function automatic logic t_lt(input logic [TW-1:0] a,
                                input logic [TW-1:0] b);
    logic [TW-1:0] d;
    d = a - b;
    return d[TW-1];
  endfunction

  function automatic logic [TW-1:0] t_max(input logic [TW-1:0] a,
                                          input logic [TW-1:0] b);
    return t_lt(a, b) ? b : a;
  endfunction

  assign lrd_prod = len_q * cfg_ps_per_byte;
  assign etf_prod = cfg_cbs_bytes * cfg_ps_per_byte;

  always_comb begin
    state_d         = state_q;
    arrival_d       = arrival_q;
    len_d           = len_q;
    tag_d           = tag_q;
    lrd_d           = lrd_q;
    etf_d           = etf_q;
    bucket_empty_d  = bucket_empty_q;
    group_elig_d    = group_elig_q;
    init_flag_d     = init_flag_q;
    sched_et_d      = sched_et_q;
    bucket_full_d   = bucket_full_q;
    elig_d          = elig_q;
    out_valid_d     = out_valid_q;
    out_elig_time_d = out_elig_time_q;
    out_discard_d   = out_discard_q;
    out_tag_d       = out_tag_q;
    residence       = elig_q - arrival_q;
    discard         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          arrival_d = local_clock;
          len_d     = in_frame_len;
          tag_d     = in_tag;
          state_d   = S_MUL;
        end
      end
      S_MUL: begin
        lrd_d = TW'(lrd_prod);
        etf_d = TW'(etf_prod);
        if (init_flag_q) begin
          bucket_empty_d = arrival_q - etf_d;
          group_elig_d   = arrival_q;
          init_flag_d    = 1'b0;
        end
        state_d = S_CMP;
      end
      S_CMP: begin
        sched_et_d    = bucket_empty_q + lrd_q;
        bucket_full_d = bucket_empty_q + etf_q;
        elig_d = t_max(t_max(arrival_q, group_elig_q), sched_et_d);
        state_d = S_DEC;
      end
      S_DEC: begin
        // Residence is a non-negative duration, so plain unsigned compare.
        discard = residence > cfg_max_residence;
        if (!discard) begin
          group_elig_d = elig_q;
          if (t_lt(elig_q, bucket_full_q))
            bucket_empty_d = sched_et_q;
          else
            bucket_empty_d = sched_et_q + (elig_q - bucket_full_q);
        end
        out_elig_time_d = elig_q;
        out_discard_d   = discard;
        out_tag_d       = tag_q;
        out_valid_d     = 1'b1;
        state_d         = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (cfg_load) init_flag_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      arrival_q       <= '0;
      len_q           <= '0;
      tag_q           <= '0;
      lrd_q           <= '0;
      etf_q           <= '0;
      bucket_empty_q  <= '0;
      group_elig_q    <= '0;
      init_flag_q     <= 1'b1;
      sched_et_q      <= '0;
      bucket_full_q   <= '0;
      elig_q          <= '0;
      out_valid_q     <= 1'b0;
      out_elig_time_q <= '0;
      out_discard_q   <= 1'b0;
      out_tag_q       <= '0;
    end else begin
      state_q         <= state_d;
      arrival_q       <= arrival_d;
      len_q           <= len_d;
      tag_q           <= tag_d;
      lrd_q           <= lrd_d;
      etf_q           <= etf_d;
      bucket_empty_q  <= bucket_empty_d;
      group_elig_q    <= group_elig_d;
      init_flag_q     <= init_flag_d;
      sched_et_q      <= sched_et_d;
      bucket_full_q   <= bucket_full_d;
      elig_q          <= elig_d;
      out_valid_q     <= out_valid_d;
      out_elig_time_q <= out_elig_time_d;
      out_discard_q   <= out_discard_d;
      out_tag_q       <= out_tag_d;
    end
  end

  assign in_ready      = (state_q == S_IDLE) && !reset;
  assign out_valid     = out_valid_q;
  assign out_elig_time = out_elig_time_q;
  assign out_discard   = out_discard_q;
  assign out_tag       = out_tag_q;

endmodule
